// File: rtl/ecp5pll_phase_ctrl.sv
// Sequencer for the ECP5 PLL dynamic phase-shift port: takes a (sel, dir, steps)
// command and generates setup/pulse/gap timed phasestep strobes, tracking net shift per output.
module ecp5pll_phase_ctrl #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sel,
  input  logic              req_dir,
  input  logic [7:0]        req_steps,
  output logic [1:0]        phasesel,
  output logic              phasedir,
  output logic              phasestep,
  output logic              phaseloadreg,
  input  logic              locked,
  output logic              busy,
  output logic              done,
  output logic              abort,
  output logic signed [9:0] phase_acc0,
  output logic signed [9:0] phase_acc1,
  output logic signed [9:0] phase_acc2,
  output logic signed [9:0] phase_acc3
);

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, GAP, FINISH} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        rem_q, rem_d;
  logic [1:0]        sel_q, sel_d;
  logic              dir_q, dir_d;
  logic              step_q, step_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic              sync1_q, lock_s_q;
  logic signed [9:0] acc_q [4];
  logic signed [9:0] acc_d [4];
  logic              accept;

  // Two's complement wrap is intentional: the accumulator is a modulo-1024 phase count.
  function automatic logic signed [9:0] acc_step(input logic signed [9:0] a, input logic lag);
    return lag ? a + 10'sd1 : a - 10'sd1;
  endfunction

  assign accept = req_valid && ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d = req_sel;
          dir_d = req_dir;
          rem_d = req_steps;
          if (req_steps == 8'd0) begin
            state_d = FINISH;
          end else begin
            state_d = SETUP;
            cnt_d   = CNT_W'(SETUP_CYC);
          end
        end
      end
      SETUP, PULSE, GAP: begin
        if (!lock_s_q) begin
          // Lock loss drops the rest of the command; an unfinished pulse is not counted.
          state_d = IDLE;
          abort_d = 1'b1;
          rem_d   = 8'd0;
        end else if (cnt_q != CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (state_q == SETUP) begin
          state_d = PULSE;
          cnt_d   = CNT_W'(PULSE_CYC);
        end else if (state_q == PULSE) begin
          state_d       = GAP;
          cnt_d         = CNT_W'(GAP_CYC);
          rem_d         = rem_q - 8'd1;
          acc_d[sel_q]  = acc_step(acc_q[sel_q], dir_q);
        end else if (rem_q != 8'd0) begin
          state_d = PULSE;
          cnt_d   = CNT_W'(PULSE_CYC);
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    step_d  = (state_d == PULSE);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE) && sync1_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      sel_q    <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
      for (int i = 0; i < 4; i++) acc_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      sel_q    <= sel_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      sync1_q  <= locked;
      lock_s_q <= sync1_q;
      acc_q    <= acc_d;
    end
  end

  assign req_ready    = ready_q;
  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign phasestep    = step_q;
  assign phaseloadreg = 1'b0;
  assign busy         = busy_q;
  assign done         = done_q;
  assign abort        = abort_q;
  assign phase_acc0   = acc_q[0];
  assign phase_acc1   = acc_q[1];
  assign phase_acc2   = acc_q[2];
  assign phase_acc3   = acc_q[3];

endmodule
